// File: rtl/ntt_pair_feeder.sv
// Streaming butterfly front-end: buffers the first DIST coefficients of each
// 2*DIST block and emits (x[p], x[p+DIST]) pairs with twiddle index, 1-cycle latency.
module ntt_pair_feeder #(
  parameter int DIST       = 4,
  parameter int N          = 256,
  parameter int TW_BASE    = 1,
  parameter int TW_WIDTH   = 8,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  pair_valid,
  output logic [DATA_WIDTH-1:0] pair [2],
  output logic [TW_WIDTH-1:0]   tw_idx,
  output logic                  frame_last
);

  localparam int POS_W = $clog2(2 * DIST);
  localparam int NBLK  = N / (2 * DIST);
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int AW    = (DIST > 1) ? $clog2(DIST) : 1;

  logic [POS_W-1:0]      pos_q, pos_d;
  logic [BLK_W-1:0]      blk_q, blk_d;
  logic                  pv_q, pv_d;
  logic                  fl_q, fl_d;
  logic [DATA_WIDTH-1:0] p0_q, p0_d;
  logic [DATA_WIDTH-1:0] p1_q, p1_d;
  logic [TW_WIDTH-1:0]   tw_q, tw_d;
  logic [DATA_WIDTH-1:0] buf_q [DIST];

  logic          pair_phase, pos_last, blk_last;
  logic [AW-1:0] addr;

  // DIST is a power of two, so pos and pos-DIST share their low bits: one address serves fill and pair phases.
  assign pair_phase = pos_q[POS_W-1];
  assign addr       = (DIST > 1) ? AW'(pos_q) : '0;
  assign pos_last   = (pos_q == POS_W'(2 * DIST - 1));
  assign blk_last   = (blk_q == BLK_W'(NBLK - 1));

  always_comb begin
    pos_d = pos_q;
    blk_d = blk_q;
    pv_d  = 1'b0;
    fl_d  = 1'b0;
    p0_d  = p0_q;
    p1_d  = p1_q;
    tw_d  = tw_q;
    if (in_valid) begin
      pos_d = pos_q + POS_W'(1);
      if (pos_last) begin
        blk_d = blk_last ? '0 : blk_q + BLK_W'(1);
      end
      if (pair_phase) begin
        pv_d = 1'b1;
        p0_d = buf_q[addr];
        p1_d = in_data;
        tw_d = TW_WIDTH'(TW_BASE) + TW_WIDTH'(blk_q);
        fl_d = pos_last && blk_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      blk_q <= '0;
      pv_q  <= 1'b0;
      fl_q  <= 1'b0;
      p0_q  <= '0;
      p1_q  <= '0;
      tw_q  <= TW_WIDTH'(TW_BASE);
    end else begin
      pos_q <= pos_d;
      blk_q <= blk_d;
      pv_q  <= pv_d;
      fl_q  <= fl_d;
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      tw_q  <= tw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && in_valid && !pair_phase) begin
      buf_q[addr] <= in_data;
    end
  end

  assign pair_valid = pv_q;
  assign frame_last = fl_q;
  assign pair[0]    = p0_q;
  assign pair[1]    = p1_q;
  assign tw_idx     = tw_q;

endmodule

// File: tb/tb_ntt_pair_feeder.sv
// Drives three differently parameterised feeders with one shared stream and
// checks each against a frame-position reference model plus directed vectors.
module tb_ntt_pair_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;

  always #5 clk = ~clk;

  logic        a_pv, b_pv, c_pv, a_fl, b_fl, c_fl;
  logic [11:0] a_pair [2];
  logic [11:0] b_pair [2];
  logic [11:0] c_pair [2];
  logic [7:0]  a_tw, b_tw, c_tw;

  ntt_pair_feeder #(.DIST(4), .N(16), .TW_BASE(1), .TW_WIDTH(8), .DATA_WIDTH(12)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pair_valid(a_pv), .pair(a_pair), .tw_idx(a_tw), .frame_last(a_fl));
  ntt_pair_feeder #(.DIST(8), .N(16), .TW_BASE(8), .TW_WIDTH(8), .DATA_WIDTH(12)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pair_valid(b_pv), .pair(b_pair), .tw_idx(b_tw), .frame_last(b_fl));
  ntt_pair_feeder #(.DIST(1), .N(4), .TW_BASE(2), .TW_WIDTH(8), .DATA_WIDTH(12)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .pair_valid(c_pv), .pair(c_pair), .tw_idx(c_tw), .frame_last(c_fl));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: each accepted input's index within its frame decides everything.
  int cfg_n  [3] = '{16, 16, 4};
  int cfg_d  [3] = '{4, 8, 1};
  int cfg_tb [3] = '{1, 8, 2};
  int k      [3];
  int fdata  [3][64];
  int m_v [3], m_p0 [3], m_p1 [3], m_tw [3], m_l [3];

  task automatic model_step(int i, bit r, bit v, int d);
    int idx, p;
    if (r) begin
      k[i] = 0; m_v[i] = 0; m_l[i] = 0; m_p0[i] = 0; m_p1[i] = 0;
      m_tw[i] = cfg_tb[i] % 256;
    end else if (v) begin
      idx = k[i] % cfg_n[i];
      fdata[i][idx] = d;
      p = idx % (2 * cfg_d[i]);
      if (p >= cfg_d[i]) begin
        m_v[i]  = 1;
        m_p0[i] = fdata[i][idx - cfg_d[i]];
        m_p1[i] = d;
        m_tw[i] = (cfg_tb[i] + idx / (2 * cfg_d[i])) % 256;
        m_l[i]  = (idx == cfg_n[i] - 1) ? 1 : 0;
      end else begin
        m_v[i] = 0; m_l[i] = 0;
      end
      k[i]++;
    end else begin
      m_v[i] = 0; m_l[i] = 0;
    end
  endtask

  task automatic cmp(string nm, int av, int a0, int a1, int atw, int al,
                     int ev, int e0, int e1, int etw, int el);
    n_vec++;
    if (av != ev || al != el || atw != etw || (ev == 1 && (a0 != e0 || a1 != e1))
        || (ev == 0 && (a0 != e0 || a1 != e1))) begin
      n_bad++;
      $display("FAIL %s t=%0t: got v=%0d pair=(%0d,%0d) tw=%0d last=%0d, want v=%0d pair=(%0d,%0d) tw=%0d last=%0d",
               nm, $time, av, a0, a1, atw, al, ev, e0, e1, etw, el);
    end
  endtask

  task automatic check_models();
    cmp("model_a", a_pv, a_pair[0], a_pair[1], a_tw, a_fl, m_v[0], m_p0[0], m_p1[0], m_tw[0], m_l[0]);
    cmp("model_b", b_pv, b_pair[0], b_pair[1], b_tw, b_fl, m_v[1], m_p0[1], m_p1[1], m_tw[1], m_l[1]);
    cmp("model_c", c_pv, c_pair[0], c_pair[1], c_tw, c_fl, m_v[2], m_p0[2], m_p1[2], m_tw[2], m_l[2]);
  endtask

  task automatic step(bit r, bit v, int d);
    @(negedge clk);
    rst = r; in_valid = v; in_data = 12'(d);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i, r, v, d);
    check_models();
  endtask

  typedef struct {
    bit r; bit v; int d;
    int ev; int e0; int e1; int etw; int el;
  } vec_t;

  vec_t tbl [17];
  int   flc, got0, got1, gottw, seen;

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      if (i < 4)       tbl[i+1] = '{0, 1, i, 0, 0, 0, 1, 0};
      else if (i < 8)  tbl[i+1] = '{0, 1, i, 1, i - 4, i, 1, 0};
      else if (i < 12) tbl[i+1] = '{0, 1, i, 0, 3, 7, 1, 0};
      else             tbl[i+1] = '{0, 1, i, 1, i - 4, i, 2, (i == 15) ? 1 : 0};
    end

    // Plain stream 0..15 on DIST=4 instance, table-checked.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      cmp("tbl", a_pv, a_pair[0], a_pair[1], a_tw, a_fl,
          tbl[i].ev, tbl[i].e0, tbl[i].e1, tbl[i].etw, tbl[i].el);
    end

    // Gaps of 3 idle cycles after inputs 2 and 5.
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, i);
      if (i == 2 || i == 5) for (int g = 0; g < 3; g++) step(0, 0, 0);
    end
    step(0, 0, 0);
    cmp("gap_hold", a_pv, a_pair[0], a_pair[1], a_tw, a_fl, 0, 11, 15, 2, 0);

    // Two frames back-to-back; frame_last exactly twice on DIST=4 instance.
    step(1, 0, 0);
    flc = 0;
    for (int i = 0; i < 32; i++) begin
      step(0, 1, i);
      if (a_fl) flc++;
    end
    cmp("two_frames_last", flc, 0, 0, 0, 0, 2, 0, 0, 0, 0);

    // Reset after input 6 mid-frame; first post-reset pair must be (100,104) tw 1.
    step(1, 0, 0);
    for (int i = 0; i <= 6; i++) step(0, 1, i);
    step(1, 0, 0);
    seen = 0; got0 = -1; got1 = -1; gottw = -1;
    for (int i = 100; i < 116; i++) begin
      step(0, 1, i);
      if (a_pv && seen == 0) begin
        seen = 1; got0 = a_pair[0]; got1 = a_pair[1]; gottw = a_tw;
      end
    end
    cmp("post_rst_first", seen, got0, got1, gottw, 0, 1, 100, 104, 1, 0);

    // rst together with in_valid drops the input; DIST=1 stage sees 5,6,7,8.
    step(1, 1, 99);
    cmp("rst_drop_c", c_pv, c_pair[0], c_pair[1], c_tw, c_fl, 0, 0, 0, 2, 0);
    step(0, 1, 5);
    step(0, 1, 6);
    cmp("dist1_pair0", c_pv, c_pair[0], c_pair[1], c_tw, c_fl, 1, 5, 6, 2, 0);
    step(0, 1, 7);
    step(0, 1, 8);
    cmp("dist1_pair1", c_pv, c_pair[0], c_pair[1], c_tw, c_fl, 1, 7, 8, 3, 1);

    // DIST=8 stage: stream 0..15 from reset, last pair (7,15) tw 8.
    step(1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, i);
    cmp("dist8_last", b_pv, b_pair[0], b_pair[1], b_tw, b_fl, 1, 7, 15, 8, 1);

    // Random traffic with gaps and occasional resets.
    step(1, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_pair_feeder.md
Name: ntt_pair_feeder

Overview:
- Streaming front-end placed directly upstream of the NTT/INTT butterfly (add_sub) in the pipelined transform.
- Accepts one coefficient per cycle and buffers the first DIST coefficients of each 2*DIST block.
- Pairs each buffered coefficient with the coefficient DIST positions later and presents the pair as the butterfly's two-element input.
- Generates the twiddle index for each pair and marks the last pair of each polynomial frame.

Parameters:
- DIST, 4, butterfly distance of this stage; power of two, 1 <= DIST <= N/2.
- N, 256, coefficients per polynomial frame; power of two.
- TW_BASE, 1, twiddle index of the first block of a frame at this stage.
- TW_WIDTH, 8, width of tw_idx.

Ports:
- clk  input  1  stage clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a coefficient this cycle.
- in_data  input  `DATA_WIDTH  coefficient, 0..Q; passed through unmodified.
- pair_valid  output  1  pair/tw_idx/frame_last are valid this cycle.
- pair  output  `DATA_WIDTH x [2] (unpacked)  pair[0] = coefficient at position p, pair[1] = coefficient at position p+DIST; matches the butterfly in[2].
- tw_idx  output  TW_WIDTH  twiddle index for this pair.
- frame_last  output  1  this pair is the final pair of the frame.

Behaviour:
- Only clk and rst exist. The reset is synchronous and active-high. No backpressure: the butterfly pipeline always accepts.
- Reset values (rst high at posedge):
  - pair_valid=0, frame_last=0, pair[0]=pair[1]=0, tw_idx=TW_BASE.
  - Position counter pos=0, block counter blk=0.
  - Buffer contents are don't-care; they are never read before being rewritten.
- Counters:
  - pos has width log2(2*DIST) and counts 0..2*DIST-1; it advances only on in_valid.
  - blk counts 0..N/(2*DIST)-1 and increments when pos wraps from 2*DIST-1 to 0.
  - blk wraps to 0 at the end of a frame.
  - Counter widths are a minimum of 1 bit.
- On a valid input with pos < DIST (fill phase):
  - Write in_data to buffer[pos].
  - pair_valid is 0 in the next cycle.
- On a valid input with pos >= DIST (pair phase):
  - Next cycle: pair[0]=buffer[pos-DIST], pair[1]=in_data, pair_valid=1.
  - tw_idx = TW_BASE + blk, truncated to TW_WIDTH.
  - frame_last=1 iff pos==2*DIST-1 and blk==N/(2*DIST)-1.
- Latency: 1 cycle from the second element's in_valid to pair_valid.
- When in_valid is low:
  - No counter or buffer change.
  - pair_valid and frame_last are 0 next cycle.
  - pair and tw_idx hold their last values.
- Gaps of any length inside a block are allowed and produce no output corruption.
- Back-to-back frames: after frame_last, the next valid input is position 0 of the next frame, with no idle cycle required.
- Buffer read and write within the same block never alias:
  - In the fill phase the buffer is only written.
  - In the pair phase it is only read.
  - Implementation is a register array of depth DIST (a shift register or an addressed array are both acceptable).
- Reset mid-operation: any partially filled block or frame is discarded. The first valid input after rst deasserts is position 0 of blk 0. No pair from pre-reset data is ever emitted.
- rst asserted together with in_valid: rst wins; the input is dropped.
- Input range is not checked; the data path is pure pass-through with no arithmetic on data.

Test Plan:
1. N=16, DIST=4, TW_BASE=1; stream values 0..15 on consecutive cycles.
   - Pairs: (0,4),(1,5),(2,6),(3,7) with tw_idx=1; then (8,12)..(11,15) with tw_idx=2.
   - pair_valid is high 1 cycle after inputs 4-7 and 12-15.
   - frame_last only on (11,15).
2. Same stream with in_valid deasserted for 3 cycles after input 2 and after input 5.
   - Identical pair sequence and tw_idx.
   - pair_valid low during gaps; pair holds its value during gaps.
3. Two frames back-to-back (values 0..31).
   - Second frame yields (16,20).. with tw_idx restarting at 1.
   - frame_last asserted exactly twice.
4. Assert rst for 1 cycle after input 6 of a frame, then stream 100..115.
   - No pair containing values 0..6.
   - First pair is (100,104) with tw_idx=1.
5. N=16, DIST=8, TW_BASE=8; stream 0..15.
   - Pairs (0,8)..(7,15), all with tw_idx=8.
   - frame_last on (7,15).
6. DIST=1, N=4, TW_BASE=2; stream 5,6,7,8.
   - Pairs (5,6) with tw_idx=2, then (7,8) with tw_idx=3 and frame_last=1.
   - rst together with in_valid on the first input drops that input.
